// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control sequencer:
// FSM states, opcode constants and the ALU / result / PC-select encodings.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC,
        WB,
        ADDR,
        MEM,
        LWB,
        BRANCH,
        JUMP,
        TRAP
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [31:0] IR_NOP = 32'h0000_0013;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SLT   = 4'b0101,
        ALU_SLL   = 4'b0110,
        ALU_SR    = 4'b0111,
        ALU_SLTU  = 4'b1000,
        ALU_PASSB = 4'b1001
    } alu_ctrl_t;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_TARGET = 2'b01;
    localparam logic [1:0] PC_JALR   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational map from opcode/funct3/funct7[5] to the ALU operation and
// the arithmetic-vs-logical right-shift select.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] alu_ctrl,
    output logic       shift_right_type
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        alu_ctrl         = ALU_ADD;
        shift_right_type = 1'b0;
        if (opcode == OP_LUI) begin
            alu_ctrl = ALU_PASSB;
        end else if (opcode == OP_R || opcode == OP_IALU) begin
            unique case (funct3)
                3'b000: alu_ctrl = (opcode == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
                3'b001: alu_ctrl = ALU_SLL;
                3'b010: alu_ctrl = ALU_SLT;
                3'b011: alu_ctrl = ALU_SLTU;
                3'b100: alu_ctrl = ALU_XOR;
                3'b101: begin
                    alu_ctrl         = ALU_SR;
                    shift_right_type = funct7_5;
                end
                3'b110: alu_ctrl = ALU_OR;
                3'b111: alu_ctrl = ALU_AND;
                default: alu_ctrl = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: latches the instruction, steps one
// state per cycle and drives the datapath strobes, PC select and instret.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic                  imem_ready,
    input  logic                  dmem_ready,
    input  logic                  Zero,
    output logic                  imem_req,
    output logic                  dmem_req,
    output logic [DATA_WIDTH-1:0] ir_out,
    output logic                  AluSrc,
    output logic [3:0]            ALUControl,
    output logic                  shift_right_type,
    output logic                  WE,
    output logic                  WE3,
    output logic [1:0]            ResultSrc,
    output logic                  pc_write,
    output logic [1:0]            pc_src,
    output logic                  illegal,
    output logic [CNT_WIDTH-1:0]  instret
);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] ir_q;
    logic [CNT_WIDTH-1:0]  instret_q;
    logic                  illegal_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [3:0] dec_alu_ctrl;
    logic       dec_srt;

    logic       ir_load, retire;
    logic       imem_req_c, dmem_req_c, alu_src_c, srt_c, we_c, we3_c, pc_write_c;
    logic [3:0] alu_ctrl_c;
    logic [1:0] result_src_c, pc_src_c;

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];

    alu_decoder u_alu_decoder (
        .opcode           (opcode),
        .funct3           (funct3),
        .funct7_5         (ir_q[30]),
        .alu_ctrl         (dec_alu_ctrl),
        .shift_right_type (dec_srt)
    );

    // NOTE: sequential state uses non-blocking assignments; reset covers only
    // the architectural registers (state, IR, counter, sticky flag).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            ir_q      <= DATA_WIDTH'(IR_NOP);
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ir_load)
                ir_q <= instr;
            if (retire)
                instret_q <= instret_q + CNT_WIDTH'(1);
            if (state_d == TRAP)
                illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        ir_load      = 1'b0;
        retire       = 1'b0;
        imem_req_c   = 1'b0;
        dmem_req_c   = 1'b0;
        alu_src_c    = 1'b0;
        alu_ctrl_c   = ALU_ADD;
        srt_c        = 1'b0;
        we_c         = 1'b0;
        we3_c        = 1'b0;
        result_src_c = RES_ALU;
        pc_write_c   = 1'b0;
        pc_src_c     = PC_PLUS4;

        unique case (state_q)
            FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ready) begin
                    ir_load = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                unique case (opcode)
                    OP_R, OP_IALU, OP_LUI: state_d = EXEC;
                    OP_LOAD, OP_STORE:     state_d = ADDR;
                    OP_BRANCH:             state_d = BRANCH;
                    OP_JAL, OP_JALR:       state_d = JUMP;
                    default:               state_d = TRAP;
                endcase
            end
            EXEC: begin
                alu_src_c  = (opcode != OP_R);
                alu_ctrl_c = dec_alu_ctrl;
                srt_c      = dec_srt;
                state_d    = WB;
            end
            WB: begin
                // ALU controls stay on so the result is still valid at write-back.
                alu_src_c  = (opcode != OP_R);
                alu_ctrl_c = dec_alu_ctrl;
                srt_c      = dec_srt;
                we3_c      = 1'b1;
                pc_write_c = 1'b1;
                retire     = 1'b1;
                state_d    = FETCH;
            end
            ADDR: begin
                alu_src_c = 1'b1;
                state_d   = MEM;
            end
            MEM: begin
                dmem_req_c = 1'b1;
                alu_src_c  = 1'b1;
                we_c       = (opcode == OP_STORE);
                if (dmem_ready) begin
                    if (opcode == OP_STORE) begin
                        // A store retires here; the PC strobe is qualified by the handshake.
                        pc_write_c = 1'b1;
                        retire     = 1'b1;
                        state_d    = FETCH;
                    end else begin
                        state_d = LWB;
                    end
                end
            end
            LWB: begin
                we3_c        = 1'b1;
                result_src_c = RES_MEM;
                pc_write_c   = 1'b1;
                retire       = 1'b1;
                state_d      = FETCH;
            end
            BRANCH: begin
                if (funct3 == 3'b000 || funct3 == 3'b001) begin
                    alu_ctrl_c = ALU_SUB;
                    pc_write_c = 1'b1;
                    pc_src_c   = ((funct3 == 3'b000) ? Zero : !Zero) ? PC_TARGET : PC_PLUS4;
                    retire     = 1'b1;
                    state_d    = FETCH;
                end else begin
                    state_d = TRAP;
                end
            end
            JUMP: begin
                we3_c        = 1'b1;
                result_src_c = RES_PC4;
                pc_write_c   = 1'b1;
                retire       = 1'b1;
                if (opcode == OP_JALR) begin
                    pc_src_c  = PC_JALR;
                    alu_src_c = 1'b1;
                end else begin
                    pc_src_c = PC_TARGET;
                end
                state_d = FETCH;
            end
            TRAP: state_d = TRAP;
            default: state_d = TRAP;
        endcase
    end

    // Reset forces every control strobe low immediately, aborting any access.
    assign imem_req         = imem_req_c & ~rst;
    assign dmem_req         = dmem_req_c & ~rst;
    assign AluSrc           = alu_src_c & ~rst;
    assign ALUControl       = rst ? 4'b0000 : alu_ctrl_c;
    assign shift_right_type = srt_c & ~rst;
    assign WE               = we_c & ~rst;
    assign WE3              = we3_c & ~rst;
    assign ResultSrc        = rst ? 2'b00 : result_src_c;
    assign pc_write         = pc_write_c & ~rst;
    assign pc_src           = rst ? 2'b00 : pc_src_c;
    assign illegal          = illegal_q & ~rst;
    assign ir_out           = ir_q;
    assign instret          = instret_q;

endmodule
